// File: rtl/core_types_pkg.sv
// core_types_pkg: shared types and constants for the memory stage.
package core_types_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_write;
  } execute_signals_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] data;
    logic [31:0] pc;
  } writeback_signals_t;

  // Access size from funct3; the unsigned bit (funct3[2]) does not change size.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_a_load_align.sv
// load_align: picks the addressed byte/halfword out of a load word and
// sign- or zero-extends it to 32 bits.
module load_align
  import core_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  // Lane select then extension; funct3[2] marks the unsigned variants.
  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    sign_en  = ~funct3[2];
    case (f3_size(funct3))
      SZ_BYTE: data = {{24{byte_sel[7] & sign_en}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15] & sign_en}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_a.sv
// mem_stage_a: memory stage between execute and writeback. Non-memory ops
// pass through in one cycle; loads/stores go through a request/response
// handshake with a bounded wait for load data.
// Optional macro MEM_MISALIGN_CHECK_EN: refuse misaligned half/word accesses
// locally (misalign_err pulse) instead of issuing them with a truncated offset.
module mem_stage_a
  import core_types_pkg::*;
#(
  parameter int RSP_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  execute_signals_t   ex_in,
  output logic               stall_out,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic [31:0]        dmem_req_addr,
  output logic               dmem_req_we,
  output logic [3:0]         dmem_req_be,
  output logic [31:0]        dmem_req_wdata,
  input  logic               dmem_rsp_valid,
  input  logic [31:0]        dmem_rsp_rdata,
  output writeback_signals_t wb_out,
  output logic               bus_err,
  output logic               misalign_err
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  writeback_signals_t wb_q, wb_d;
  logic               bus_err_q, bus_err_d;
  logic               misalign_err_q, misalign_err_d;

  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [31:0] pc_q, pc_d;

  logic        is_load, is_store, is_mem;
  mem_size_e   size;
  logic        wr_nz;
  logic        reject;
  logic        cap_en;
  logic [31:0] load_data;
  logic        unused_ex;

  assign unused_ex = ^{ex_in.inst[31:15], ex_in.inst[11:7], ex_in.mem_write};

  // Decode the execute result into request fields; the offset is truncated
  // to the access size so misaligned halves/words land on their natural lanes.
  always_comb begin
    is_load  = (ex_in.inst[6:0] == OP_LOAD);
    is_store = (ex_in.inst[6:0] == OP_STORE);
    is_mem   = is_load | is_store;
    size     = f3_size(ex_in.inst[14:12]);
    wr_nz    = ex_in.reg_write & (ex_in.rd != 5'd0);
    addr_d   = {ex_in.mem_addr[31:2], 2'b00};
    we_d     = is_store;
    f3_d     = ex_in.inst[14:12];
    rd_d     = ex_in.rd;
    rw_d     = wr_nz & is_load;
    pc_d     = ex_in.pc;
    case (size)
      SZ_BYTE: begin
        off_d   = ex_in.mem_addr[1:0];
        be_d    = 4'b0001 << off_d;
        wdata_d = {4{ex_in.mem_data[7:0]}};
      end
      SZ_HALF: begin
        off_d   = {ex_in.mem_addr[1], 1'b0};
        be_d    = 4'b0011 << off_d;
        wdata_d = {2{ex_in.mem_data[15:0]}};
      end
      default: begin
        off_d   = 2'b00;
        be_d    = 4'b1111;
        wdata_d = ex_in.mem_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Flag half/word accesses whose address is not naturally aligned.
  always_comb begin
    reject = 1'b0;
    if (size == SZ_HALF)      reject = ex_in.mem_addr[0];
    else if (size == SZ_WORD) reject = (ex_in.mem_addr[1:0] != 2'b00);
  end
`else
  assign reject = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (dmem_rsp_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // FSM next state, writeback record, error pulses and upstream stall.
  // Stall drops in the cycle that completes the operation so the execute
  // stage advances on the same edge the state returns to IDLE.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wb_d           = '0;
    bus_err_d      = 1'b0;
    misalign_err_d = 1'b0;
    cap_en         = 1'b0;
    stall_out      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_in.valid) begin
          if (!is_mem) begin
            wb_d.valid     = 1'b1;
            wb_d.rd        = ex_in.rd;
            wb_d.reg_write = wr_nz;
            wb_d.data      = ex_in.result;
            wb_d.pc        = ex_in.pc;
          end else if (reject) begin
            wb_d.valid     = 1'b1;
            wb_d.rd        = ex_in.rd;
            wb_d.pc        = ex_in.pc;
            misalign_err_d = 1'b1;
          end else begin
            cap_en    = 1'b1;
            stall_out = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        stall_out = 1'b1;
        if (dmem_req_ready) begin
          if (we_q) begin
            stall_out  = 1'b0;
            state_d    = IDLE;
            wb_d.valid = 1'b1;
            wb_d.rd    = rd_q;
            wb_d.pc    = pc_q;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        stall_out = 1'b1;
        if (dmem_rsp_valid) begin
          stall_out      = 1'b0;
          state_d        = IDLE;
          wb_d.valid     = 1'b1;
          wb_d.rd        = rd_q;
          wb_d.reg_write = rw_q;
          wb_d.data      = load_data;
          wb_d.pc        = pc_q;
        end else if (cnt_q == CNT_LAST) begin
          stall_out  = 1'b0;
          state_d    = IDLE;
          bus_err_d  = 1'b1;
          wb_d.valid = 1'b1;
          wb_d.rd    = rd_q;
          wb_d.pc    = pc_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset_n) stall_out = 1'b0;
  end

  // Control state and registered outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wb_q           <= '0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_q           <= wb_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Request capture; held unchanged for the whole REQ/WAIT_RSP sequence.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      pc_q    <= pc_d;
    end
  end

  assign dmem_req_valid = (state_q == REQ);
  assign dmem_req_addr  = addr_q;
  assign dmem_req_we    = we_q;
  assign dmem_req_be    = be_q;
  assign dmem_req_wdata = wdata_q;
  assign wb_out         = wb_q;
  assign bus_err        = bus_err_q;
  assign misalign_err   = misalign_err_q;

endmodule

// File: tb/tb_mem_stage_a.sv
// tb_mem_stage_a: table-driven vectors with a writeback scoreboard, plus
// hand sequences for load timeout and reset during an outstanding load.
module tb_mem_stage_a;
  import core_types_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic               clk;
  logic               reset_n;
  execute_signals_t   ex_in;
  logic               stall_out;
  logic               dmem_req_valid;
  logic               dmem_req_ready;
  logic [31:0]        dmem_req_addr;
  logic               dmem_req_we;
  logic [3:0]         dmem_req_be;
  logic [31:0]        dmem_req_wdata;
  logic               dmem_rsp_valid;
  logic [31:0]        dmem_rsp_rdata;
  writeback_signals_t wb_out;
  logic               bus_err;
  logic               misalign_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          rdy;
    int          rsp;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        misal;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] pc;
    logic        bus_err;
    logic        misal;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[15];

  mem_stage_a #(.RSP_TIMEOUT(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_in          (ex_in),
    .stall_out      (stall_out),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_be    (dmem_req_be),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .wb_out         (wb_out),
    .bus_err        (bus_err),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback monitor: every valid writeback must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (wb_out.valid) begin
      check("wb_expected", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wb_rd", 64'(wb_out.rd), 64'(e.rd));
        check("wb_reg_write", 64'(wb_out.reg_write), 64'(e.rw));
        if (e.chk_data) check("wb_data", 64'(wb_out.data), 64'(e.data));
        check("wb_pc", 64'(wb_out.pc), 64'(e.pc));
        check("wb_bus_err", 64'(bus_err), 64'(e.bus_err));
        check("wb_misalign_err", 64'(misalign_err), 64'(e.misal));
      end
    end else begin
      check("bus_err_quiet", 64'(bus_err), 64'(0));
      check("misalign_quiet", 64'(misalign_err), 64'(0));
    end
  end

  task automatic run_op(input vec_t v, input int idx);
    logic is_load, is_mem, issued;
    exp_t e;
    int   stalls;
    is_load = (v.op == OP_LOAD);
    is_mem  = is_load || (v.op == OP_STORE);
    issued  = is_mem;
`ifdef MEM_MISALIGN_CHECK_EN
    if (v.misal) issued = 1'b0;
`endif
    ex_in           = '0;
    ex_in.valid     = 1'b1;
    ex_in.rd        = v.rd;
    ex_in.reg_write = 1'b1;
    ex_in.pc        = 32'h100 + 32'(idx) * 4;
    ex_in.inst      = {17'd0, v.f3, 5'd0, v.op};
    ex_in.result    = v.result;
    ex_in.mem_addr  = v.addr;
    ex_in.mem_data  = v.sdata;
    ex_in.mem_write = (v.op == OP_STORE);
    e.rd       = v.rd;
    e.rw       = (is_mem && !issued) ? 1'b0 : v.exp_rw;
    e.data     = v.exp_data;
    e.chk_data = !is_mem || (is_load && issued);
    e.pc       = ex_in.pc;
    e.bus_err  = 1'b0;
    e.misal    = is_mem && !issued;
    sb_q.push_back(e);
    if (!issued) begin
      @(negedge clk);
      check("stall_idle", 64'(stall_out), 64'(0));
      check("req_idle", 64'(dmem_req_valid), 64'(0));
      @(posedge clk); #1;
      ex_in.valid = 1'b0;
      @(negedge clk);
      check("req_after_idle", 64'(dmem_req_valid), 64'(0));
    end else begin
      stalls = 0;
      @(negedge clk);
      check("stall_issue", 64'(stall_out), 64'(1));
      if (stall_out) stalls++;
      for (int c = 0; c <= v.rdy; c++) begin
        @(posedge clk); #1;
        dmem_req_ready = (c == v.rdy);
        @(negedge clk);
        check("req_valid", 64'(dmem_req_valid), 64'(1));
        check("req_addr", 64'(dmem_req_addr), 64'({v.addr[31:2], 2'b00}));
        check("req_we", 64'(dmem_req_we), 64'(!is_load));
        if (v.exp_be != 4'h0) check("req_be", 64'(dmem_req_be), 64'(v.exp_be));
        if (!is_load) check("req_wdata", 64'(dmem_req_wdata), 64'(v.exp_wdata));
        check("stall_req", 64'(stall_out), 64'(!(c == v.rdy && !is_load)));
        if (stall_out) stalls++;
      end
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      if (is_load) begin
        for (int c = 0; c <= v.rsp; c++) begin
          if (c == v.rsp) begin
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = v.rdata;
          end
          @(negedge clk);
          check("req_in_wait", 64'(dmem_req_valid), 64'(0));
          check("stall_wait", 64'(stall_out), 64'(c != v.rsp));
          @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'hFFFF_FFFF;
      end else begin
        check("stall_cycles", 64'(stalls), 64'(1 + v.rdy));
      end
      ex_in.valid = 1'b0;
      @(negedge clk);
      check("req_after_op", 64'(dmem_req_valid), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic got;
    exp_t e;
    //          op        f3      rd     result        addr          sdata         rdata         rdy rsp exp_data      rw    be     wdata         misal
    vecs[0]  = '{OP_ALU,   3'b000, 5'd5,  32'h0000_0042, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0042, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[1]  = '{OP_STORE, F3_B,   5'd0,  32'h0,         32'h0000_1003, 32'h0000_00AB, 32'h0,       2, 0, 32'h0,         1'b0, 4'h8, 32'hABAB_ABAB, 1'b0};
    vecs[2]  = '{OP_LOAD,  F3_H,   5'd6,  32'h0,         32'h0000_2002, 32'h0,        32'h8001_1234, 0, 1, 32'hFFFF_8001, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[3]  = '{OP_LOAD,  F3_HU,  5'd7,  32'h0,         32'h0000_2002, 32'h0,        32'h8001_1234, 0, 0, 32'h0000_8001, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[4]  = '{OP_LOAD,  F3_B,   5'd8,  32'h0,         32'h0000_1001, 32'h0,        32'h1234_F0AA, 1, 0, 32'hFFFF_FFF0, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{OP_LOAD,  F3_BU,  5'd9,  32'h0,         32'h0000_1003, 32'h0,        32'h7F00_0000, 0, 0, 32'h0000_007F, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[6]  = '{OP_LOAD,  F3_W,   5'd10, 32'h0,         32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{OP_STORE, F3_H,   5'd0,  32'h0,         32'h0000_2002, 32'h1234_5678, 32'h0,       0, 0, 32'h0,         1'b0, 4'hC, 32'h5678_5678, 1'b0};
    vecs[8]  = '{OP_STORE, F3_W,   5'd0,  32'h0,         32'h0000_3000, 32'hCAFE_F00D, 32'h0,       1, 0, 32'h0,         1'b0, 4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{OP_LOAD,  F3_B,   5'd0,  32'h0,         32'h0000_1000, 32'h0,        32'h0000_0055, 0, 0, 32'h0000_0055, 1'b0, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{OP_LOAD,  F3_W,   5'd11, 32'h0,         32'h0000_3001, 32'h0,        32'h1122_3344, 0, 0, 32'h1122_3344, 1'b1, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{OP_LOAD,  F3_H,   5'd12, 32'h0,         32'h0000_2003, 32'h0,        32'hA5A5_0000, 0, 0, 32'hFFFF_A5A5, 1'b1, 4'h0, 32'h0,        1'b1};
    vecs[12] = '{OP_ALU,   3'b100, 5'd0,  32'h0000_0007, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0007, 1'b0, 4'h0, 32'h0,        1'b0};
    vecs[13] = '{OP_STORE, F3_H,   5'd0,  32'h0,         32'h0000_0001, 32'h0000_BEEF, 32'h0,       0, 0, 32'h0,         1'b0, 4'h3, 32'hBEEF_BEEF, 1'b1};
    vecs[14] = '{OP_STORE, F3_B,   5'd0,  32'h0,         32'h0000_2000, 32'h0000_005A, 32'h0,       0, 0, 32'h0,         1'b0, 4'h1, 32'h5A5A_5A5A, 1'b0};

    reset_n        = 1'b0;
    ex_in          = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_zero", 64'(wb_out == '0), 64'(1));
    check("rst_stall", 64'(stall_out), 64'(0));
    check("rst_req_valid", 64'(dmem_req_valid), 64'(0));
    check("rst_bus_err", 64'(bus_err), 64'(0));
    check("rst_misalign", 64'(misalign_err), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i], i);
      @(posedge clk); #1;
    end

    // Load with no response: timeout after four WAIT_RSP cycles.
    ex_in           = '0;
    ex_in.valid     = 1'b1;
    ex_in.rd        = 5'd7;
    ex_in.reg_write = 1'b1;
    ex_in.pc        = 32'h500;
    ex_in.inst      = {17'd0, F3_W, 5'd0, OP_LOAD};
    ex_in.mem_addr  = 32'h0000_5000;
    e = '{rd: 5'd7, rw: 1'b0, data: 32'h0, chk_data: 1'b0, pc: 32'h500, bus_err: 1'b1, misal: 1'b0};
    sb_q.push_back(e);
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    ex_in.valid    = 1'b0;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    waited = 0;
    got    = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus_err) got = 1'b1;
      else waited++;
      @(posedge clk); #1;
    end
    check("timeout_seen", 64'(got), 64'(1));
    check("timeout_cycles", 64'(waited), 64'(4));
    @(negedge clk);
    check("bus_err_pulse", 64'(bus_err), 64'(0));
    check("stall_after_timeout", 64'(stall_out), 64'(0));
    @(posedge clk); #1;

    // Reset in the middle of WAIT_RSP, then a stray response.
    ex_in           = '0;
    ex_in.valid     = 1'b1;
    ex_in.rd        = 5'd9;
    ex_in.reg_write = 1'b1;
    ex_in.pc        = 32'h600;
    ex_in.inst      = {17'd0, F3_W, 5'd0, OP_LOAD};
    ex_in.mem_addr  = 32'h0000_6000;
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    ex_in.valid    = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("stall_in_reset", 64'(stall_out), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_wb_zero", 64'(wb_out == '0), 64'(1));
    check("post_rst_req_valid", 64'(dmem_req_valid), 64'(0));
    check("post_rst_stall", 64'(stall_out), 64'(0));
    check("post_rst_bus_err", 64'(bus_err), 64'(0));
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check("wb_after_stray", 64'(wb_out.valid), 64'(0));
    check("stall_after_stray", 64'(stall_out), 64'(0));
    @(posedge clk); #1;

    // Normal load still works after the abandoned one.
    run_op(vecs[6], 20);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_a.md
MEM_STAGE_A -- requirements
Module: mem_stage_a

Interface
REQ-001 Parameter RSP_TIMEOUT, default 64, max cycles waited in WAIT_RSP for a load response before abort.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 ex_in  input  execute_signals_t  execute-stage result (valid, rd, reg_write, pc, inst, result, mem_addr, mem_data, mem_write).
REQ-005 stall_out  output  1  upstream hold; while 1, execute stage keeps ex_in stable.
REQ-006 dmem_req_valid  output  1  data-memory request valid.
REQ-007 dmem_req_ready  input  1  memory accepts request this cycle.
REQ-008 dmem_req_addr  output  32  word-aligned address {mem_addr[31:2],2'b00}.
REQ-009 dmem_req_we  output  1  1 = store, 0 = load.
REQ-010 dmem_req_be  output  4  byte enables.
REQ-011 dmem_req_wdata  output  32  lane-aligned store data.
REQ-012 dmem_rsp_valid  input  1  load data valid, one-cycle pulse.
REQ-013 dmem_rsp_rdata  input  32  load word.
REQ-014 wb_out  output  writeback_signals_t  registered (valid, rd, reg_write, data, pc) to register file.
REQ-015 bus_err  output  1  one-cycle pulse on load timeout.
REQ-016 misalign_err  output  1  one-cycle pulse on misaligned access (see Configuration).

Function
REQ-017 Load = ex_in.inst[6:0]==OP_LOAD; store = OP_STORE; size/sign from ex_in.inst[14:12]; other valid instructions are non-memory.
REQ-018 FSM states IDLE, REQ, WAIT_RSP; non-memory ops never leave IDLE.
REQ-019 IDLE, valid non-memory op: wb_out = {1, rd, reg_write, result, pc} next cycle (latency 1); stall_out=0.
REQ-020 IDLE, valid memory op: capture request fields, go REQ; stall_out=1 combinationally that same cycle.
REQ-021 REQ: dmem_req_valid=1, all request fields stable until dmem_req_ready; store + ready -> IDLE, wb_out.valid=1 with reg_write=0 next cycle; load + ready -> WAIT_RSP.
REQ-022 WAIT_RSP: dmem_rsp_valid -> wb_out.data = aligned load, reg_write from capture, valid=1 next cycle, -> IDLE; dmem_rsp_valid outside WAIT_RSP ignored.
REQ-023 WAIT_RSP timeout counter reset on entry; reaching RSP_TIMEOUT with no response -> bus_err pulse, wb_out.valid=1 with reg_write=0, -> IDLE; response and timeout in same cycle: response wins.
REQ-024 stall_out=1 in REQ and WAIT_RSP, deasserted in the cycle the state returns to IDLE.
REQ-025 wb_out.valid=0 every cycle not covered by REQ-019/021/022/023; dmem_req_valid=0 outside REQ.
REQ-026 Loads: LB/LBU byte at offset addr[1:0], LH/LHU halfword at addr[1]; sign-extend LB/LH, zero-extend LBU/LHU; LW full word.
REQ-027 Stores: SB be=4'b0001<<addr[1:0], byte replicated on all lanes; SH be=4'b0011<<(2*addr[1]), halfword replicated; SW be=4'b1111.
REQ-028 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-029 rd=x0 writebacks forced reg_write=0.

Reset
REQ-030 reset_n=0 at posedge: state IDLE, timeout counter 0, wb_out='0, bus_err=0, misalign_err=0, dmem_req_valid=0; outstanding request/response abandoned mid-operation.
REQ-031 stall_out=0 while in reset.

Configuration
REQ-032 Macro MEM_MISALIGN_CHECK_EN defined: misaligned op is not issued, stays IDLE, misalign_err pulses with wb_out.valid=1, reg_write=0 next cycle.
REQ-033 Macro undefined: misalign_err tied 0; misaligned ops issued using offset truncated to access size (addr[0] ignored for halves, addr[1:0] for words).

Structure
REQ-034 core_types_pkg holds writeback_signals_t, mem_state_e, OP_LOAD/OP_STORE and funct3 size constants.
REQ-035 One sub-module load_align: combinational rdata/offset/funct3 -> extended 32-bit data.

Verification
REQ-036 ADD result 0x0000_0042 rd=5 -> wb_out valid next cycle, data 0x42, rd 5, no dmem request.
REQ-037 SB addr 0x1003 data 0xAB, ready after 2 cycles -> addr 0x1000, be 4'b1000, wdata 0xABABABAB held stable, stall_out high 3 cycles.
REQ-038 LH addr 0x2002, rdata 0x8001_1234 -> wb_out.data 0xFFFF_8001; LHU same -> 0x0000_8001.
REQ-039 LW, no response, RSP_TIMEOUT=4 -> bus_err pulse after 4 WAIT_RSP cycles, reg_write=0, back to IDLE.
REQ-040 LW addr 0x3001 with MEM_MISALIGN_CHECK_EN -> no dmem_req_valid, misalign_err pulse; without macro -> request at 0x3000, be 4'b1111.
REQ-041 reset_n low during WAIT_RSP -> IDLE next cycle, outputs zero, later stray dmem_rsp_valid ignored.
